mem_seq_ctrl: RTL and testbench
===============================

MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 17: memory address width.
REQ-002 SHALL have parameter PLENGTH, default 256: page length in bytes.
REQ-003 SHALL have parameters TPP / TSE / TBE, defaults 64 / 256 / 1024: busy cycles for page program, sector erase and bulk erase.
REQ-004 SHALL have ports, one per line:
- c  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sel_n  in  1  chip select, active-low, synchronous to c.
- byte_valid  in  1  one-cycle strobe qualifying byte_in.
- byte_in  in  8  command/address/data byte.
- add_mem  out  ADDR_W  operation start address.
- read_enable, add_pp_enable, pp_enable, se_enable, be_enable  out  1 each  memory-array controls.
- data_request  out  1  read byte request.
- data_to_write  out  8  page-buffer data.
- page_add_index  out  8  page-buffer index.
- wip  out  1  write in progress.
- wel  out  1  write-enable latch.
- cmd_err  out  1  one-cycle error pulse.

Function
REQ-005 SHALL decode opcodes 06h WREN, 04h WRDI, 03h READ, 02h PP, D8h SE and C7h BE; any other opcode is illegal.
REQ-006 SHALL implement states IDLE, ADDR2, ADDR1, ADDR0, READ, PP_DATA, WAIT_DESEL, BUSY_PP, BUSY_SE and BUSY_BE.
REQ-007 SHALL treat the first byte_valid with sel_n=0 in IDLE as the opcode.
REQ-008 SHALL handle the single-byte opcodes as follows:
- WREN sets wel, then goes to WAIT_DESEL.
- WRDI clears wel, then goes to WAIT_DESEL.
- BE goes to WAIT_DESEL.
- READ, PP and SE go to ADDR2.
REQ-009 SHALL take address bytes MSB first (ADDR2, ADDR1, ADDR0) and keep only the low ADDR_W bits.
REQ-010 SHALL register add_mem in the cycle ADDR0 is accepted and hold it until the operation ends.
REQ-011 SHALL assert the associated enable exactly one cycle after add_mem updates.
REQ-012 READ SHALL behave as follows:
- read_enable rises one cycle after add_mem updates.
- Each byte_valid in READ produces a one-cycle data_request pulse in the next cycle.
- read_enable falls in the cycle after sel_n=1.
REQ-013 PP address phase SHALL behave as follows:
- In the ADDR0 cycle, page_add_index is set to add[7:0]-1 mod 256.
- add_pp_enable rises the next cycle only if wel=1.
REQ-014 PP data phase SHALL behave as follows:
- Each data byte sets data_to_write=byte_in and page_add_index+1 mod 256 in the same cycle.
- The index wraps within the page; byte 257 overwrites byte 1.
REQ-015 SHALL hold pp_enable at 0 during PP_DATA.
REQ-016 SHALL start programming on sel_n rising in PP_DATA when wel=1 and at least one data byte was received:
- enter BUSY_PP with pp_enable=1 and wip=1 for TPP cycles;
- then drop pp_enable and add_pp_enable in the same cycle and clear wip and wel.
REQ-017 On sel_n rising in PP_DATA with zero data bytes, SHALL drop add_pp_enable and return to IDLE with no pulse.
REQ-018 SE SHALL require exactly 4 bytes and wel=1 at deselect:
- se_enable rises one cycle after deselect and stays high TSE cycles;
- wip=1 throughout; at the falling edge, wip and wel clear.
REQ-019 BE SHALL require exactly 1 byte and wel=1 at deselect:
- be_enable stays high TBE cycles with the same wip/wel rules as SE.
REQ-020 SHALL pulse cmd_err for one cycle, perform no array action and return to IDLE in each of these cases:
- PP, SE or BE with wel=0;
- wrong byte count for SE or BE;
- deselect before the address is complete;
- an illegal opcode.
REQ-021 SHALL ignore byte_valid and sel_n while in BUSY_*.
REQ-022 SHALL pulse cmd_err on any byte_valid received during BUSY_*.
REQ-023 Busy counters SHALL count TPP/TSE/TBE cycles exactly; deselect SHALL be sampled only while in non-busy states.
REQ-024 SHALL ignore byte_valid while sel_n=1.
REQ-025 SHALL ignore extra bytes in WAIT_DESEL, except for the SE/BE byte count.

Reset
REQ-026 SHALL, while rst_n=0, drive every output to 0, clear all state and go to IDLE immediately (asynchronous).
REQ-027 SHALL, when reset is asserted mid-busy, abort the operation and clear wel.
REQ-028 SHALL resume operation on the first c edge after rst_n deasserts.

Verification
REQ-029 Read: WREN-free READ 03h,00h,01h,23h then 3 dummy bytes -> add_mem=00123h, read_enable high 1 cycle later, 3 data_request pulses, read_enable low after sel_n=1.
REQ-030 Page program: WREN; PP 02h,00h,02h,FEh, data AAh,BBh,CCh -> page_add_index sequence FEh,FFh,00h with data_to_write AAh,BBh,CCh; pp_enable high exactly 64 cycles; then wip=0, wel=0.
REQ-031 Write protect: PP without WREN -> cmd_err pulse, add_pp_enable/pp_enable never high, wip=0.
REQ-032 Sector erase: WREN; SE D8h,01h,00h,00h -> se_enable high 256 cycles with add_mem=10000h; SE with 5 bytes -> cmd_err and no se_enable.
REQ-033 Busy/reset: BE accepted, bytes sent during busy -> cmd_err each, be_enable stays high 1024 cycles; repeat with rst_n low at cycle 100 -> all outputs 0 at once.

Source files
------------

// File: rtl/mem_seq_ctrl.sv
// Serial command sequencer for a page-programmable memory: decodes opcode/address/data bytes into array controls.
// Latency: outputs are registered, one cycle after the byte or deselect that causes them. Bytes are not backpressured.
module mem_seq_ctrl #(
    parameter int ADDR_W  = 17,
    parameter int PLENGTH = 256,
    parameter int TPP     = 64,
    parameter int TSE     = 256,
    parameter int TBE     = 1024
) (
    input  logic              c,
    input  logic              rst_n,
    input  logic              sel_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic [ADDR_W-1:0] add_mem,
    output logic              read_enable,
    output logic              add_pp_enable,
    output logic              pp_enable,
    output logic              se_enable,
    output logic              be_enable,
    output logic              data_request,
    output logic [7:0]        data_to_write,
    output logic [7:0]        page_add_index,
    output logic              wip,
    output logic              wel,
    output logic              cmd_err
);

    localparam int TMAX  = (TPP > TSE) ? ((TPP > TBE) ? TPP : TBE) : ((TSE > TBE) ? TSE : TBE);
    localparam int CNT_W = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR2, ADDR1, ADDR0, READ, PP_DATA, WAIT_DESEL, BUSY_PP, BUSY_SE, BUSY_BE
    } state_t;

    typedef enum logic [2:0] {
        OP_WREN, OP_WRDI, OP_READ, OP_PP, OP_SE, OP_BE
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [7:0]        a2_q, a2_d, a1_q, a1_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic              data_seen_q, data_seen_d;
    logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
    logic [ADDR_W-1:0] add_mem_q, add_mem_d;
    logic              read_enable_q, read_enable_d;
    logic              add_pp_enable_q, add_pp_enable_d;
    logic              pp_enable_q, pp_enable_d;
    logic              se_enable_q, se_enable_d;
    logic              be_enable_q, be_enable_d;
    logic              data_request_q, data_request_d;
    logic [7:0]        data_to_write_q, data_to_write_d;
    logic [7:0]        page_add_index_q, page_add_index_d;
    logic              wip_q, wip_d;
    logic              wel_q, wel_d;
    logic              cmd_err_q, cmd_err_d;

    logic take;
    assign take = byte_valid && !sel_n;

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        a2_d             = a2_q;
        a1_d             = a1_q;
        byte_cnt_d       = byte_cnt_q;
        data_seen_d      = data_seen_q;
        busy_cnt_d       = busy_cnt_q;
        add_mem_d        = add_mem_q;
        read_enable_d    = read_enable_q;
        add_pp_enable_d  = add_pp_enable_q;
        pp_enable_d      = pp_enable_q;
        se_enable_d      = se_enable_q;
        be_enable_d      = be_enable_q;
        data_request_d   = 1'b0;
        data_to_write_d  = data_to_write_q;
        page_add_index_d = page_add_index_q;
        wip_d            = wip_q;
        wel_d            = wel_q;
        cmd_err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (take) begin
                    byte_cnt_d = 3'd1;
                    case (byte_in)
                        8'h06: begin op_d = OP_WREN; wel_d = 1'b1; state_d = WAIT_DESEL; end
                        8'h04: begin op_d = OP_WRDI; wel_d = 1'b0; state_d = WAIT_DESEL; end
                        8'hC7: begin op_d = OP_BE;   state_d = WAIT_DESEL; end
                        8'h03: begin op_d = OP_READ; state_d = ADDR2; end
                        8'h02: begin op_d = OP_PP;   state_d = ADDR2; end
                        8'hD8: begin op_d = OP_SE;   state_d = ADDR2; end
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end
            ADDR2, ADDR1: begin
                if (sel_n) begin
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                end else if (byte_valid) begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (state_q == ADDR2) begin
                        a2_d    = byte_in;
                        state_d = ADDR1;
                    end else begin
                        a1_d    = byte_in;
                        state_d = ADDR0;
                    end
                end
            end
            ADDR0: begin
                if (sel_n) begin
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                end else if (byte_valid) begin
                    add_mem_d  = ADDR_W'({a2_q, a1_q, byte_in});
                    byte_cnt_d = 3'd4;
                    case (op_q)
                        OP_READ: state_d = READ;
                        OP_PP: begin
                            // Pre-decrement so the first data byte lands on the start address.
                            page_add_index_d = byte_in - 8'd1;
                            data_seen_d      = 1'b0;
                            state_d          = PP_DATA;
                        end
                        default: state_d = WAIT_DESEL;
                    endcase
                end
            end
            READ: begin
                if (sel_n) begin
                    read_enable_d = 1'b0;
                    state_d       = IDLE;
                end else begin
                    read_enable_d  = 1'b1;
                    data_request_d = byte_valid;
                end
            end
            PP_DATA: begin
                if (sel_n) begin
                    add_pp_enable_d = 1'b0;
                    state_d         = IDLE;
                    if (!wel_q) begin
                        cmd_err_d = 1'b1;
                    end else if (data_seen_q) begin
                        add_pp_enable_d = 1'b1;
                        pp_enable_d     = 1'b1;
                        wip_d           = 1'b1;
                        busy_cnt_d      = CNT_W'(TPP - 1);
                        state_d         = BUSY_PP;
                    end
                end else begin
                    add_pp_enable_d = wel_q;
                    if (byte_valid) begin
                        data_to_write_d  = byte_in;
                        page_add_index_d = (page_add_index_q == 8'(PLENGTH - 1)) ? 8'd0
                                                                                 : page_add_index_q + 8'd1;
                        data_seen_d      = 1'b1;
                    end
                end
            end
            WAIT_DESEL: begin
                if (sel_n) begin
                    state_d = IDLE;
                    if (op_q == OP_SE) begin
                        if (wel_q && byte_cnt_q == 3'd4) begin
                            se_enable_d = 1'b1;
                            wip_d       = 1'b1;
                            busy_cnt_d  = CNT_W'(TSE - 1);
                            state_d     = BUSY_SE;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end else if (op_q == OP_BE) begin
                        if (wel_q && byte_cnt_q == 3'd1) begin
                            be_enable_d = 1'b1;
                            wip_d       = 1'b1;
                            busy_cnt_d  = CNT_W'(TBE - 1);
                            state_d     = BUSY_BE;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end
                end else if (byte_valid && byte_cnt_q != 3'd7) begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                end
            end
            BUSY_PP, BUSY_SE, BUSY_BE: begin
                // sel_n is deliberately not looked at here; only the counter ends the operation.
                cmd_err_d = byte_valid;
                if (busy_cnt_q == '0) begin
                    add_pp_enable_d = 1'b0;
                    pp_enable_d     = 1'b0;
                    se_enable_d     = 1'b0;
                    be_enable_d     = 1'b0;
                    wip_d           = 1'b0;
                    wel_d           = 1'b0;
                    state_d         = IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            op_q             <= OP_WREN;
            a2_q             <= '0;
            a1_q             <= '0;
            byte_cnt_q       <= '0;
            data_seen_q      <= 1'b0;
            busy_cnt_q       <= '0;
            add_mem_q        <= '0;
            read_enable_q    <= 1'b0;
            add_pp_enable_q  <= 1'b0;
            pp_enable_q      <= 1'b0;
            se_enable_q      <= 1'b0;
            be_enable_q      <= 1'b0;
            data_request_q   <= 1'b0;
            data_to_write_q  <= '0;
            page_add_index_q <= '0;
            wip_q            <= 1'b0;
            wel_q            <= 1'b0;
            cmd_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            a2_q             <= a2_d;
            a1_q             <= a1_d;
            byte_cnt_q       <= byte_cnt_d;
            data_seen_q      <= data_seen_d;
            busy_cnt_q       <= busy_cnt_d;
            add_mem_q        <= add_mem_d;
            read_enable_q    <= read_enable_d;
            add_pp_enable_q  <= add_pp_enable_d;
            pp_enable_q      <= pp_enable_d;
            se_enable_q      <= se_enable_d;
            be_enable_q      <= be_enable_d;
            data_request_q   <= data_request_d;
            data_to_write_q  <= data_to_write_d;
            page_add_index_q <= page_add_index_d;
            wip_q            <= wip_d;
            wel_q            <= wel_d;
            cmd_err_q        <= cmd_err_d;
        end
    end

    assign add_mem        = add_mem_q;
    assign read_enable    = read_enable_q;
    assign add_pp_enable  = add_pp_enable_q;
    assign pp_enable      = pp_enable_q;
    assign se_enable      = se_enable_q;
    assign be_enable      = be_enable_q;
    assign data_request   = data_request_q;
    assign data_to_write  = data_to_write_q;
    assign page_add_index = page_add_index_q;
    assign wip            = wip_q;
    assign wel            = wel_q;
    assign cmd_err        = cmd_err_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl: read, page program, write protect, erases, busy-time bytes and reset abort.
module tb_mem_seq_ctrl;

    localparam int ADDR_W = 17;

    logic              c = 1'b0;
    logic              rst_n;
    logic              sel_n;
    logic              byte_valid;
    logic [7:0]        byte_in;
    logic [ADDR_W-1:0] add_mem;
    logic              read_enable, add_pp_enable, pp_enable, se_enable, be_enable;
    logic              data_request;
    logic [7:0]        data_to_write, page_add_index;
    logic              wip, wel, cmd_err;

    int   n_chk = 0;
    int   n_err = 0;
    int   err_pulses = 0;
    int   req_pulses = 0;
    logic acc_ppa = 1'b0, acc_pp = 1'b0, acc_se = 1'b0;

    always #5 c = ~c;

    mem_seq_ctrl #(.ADDR_W(ADDR_W)) dut (
        .c              (c),
        .rst_n          (rst_n),
        .sel_n          (sel_n),
        .byte_valid     (byte_valid),
        .byte_in        (byte_in),
        .add_mem        (add_mem),
        .read_enable    (read_enable),
        .add_pp_enable  (add_pp_enable),
        .pp_enable      (pp_enable),
        .se_enable      (se_enable),
        .be_enable      (be_enable),
        .data_request   (data_request),
        .data_to_write  (data_to_write),
        .page_add_index (page_add_index),
        .wip            (wip),
        .wel            (wel),
        .cmd_err        (cmd_err)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
        if (cmd_err) err_pulses++;
        if (data_request) req_pulses++;
        acc_ppa |= add_pp_enable;
        acc_pp  |= pp_enable;
        acc_se  |= se_enable;
    endtask

    task automatic clr_acc();
        err_pulses = 0;
        req_pulses = 0;
        acc_ppa    = 1'b0;
        acc_pp     = 1'b0;
        acc_se     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        sel_n      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic deselect();
        sel_n      = 1'b1;
        byte_valid = 1'b0;
        tick();
    endtask

    task automatic do_wren();
        send_byte(8'h06);
        deselect();
    endtask

    // Samples the selected enable each cycle, optionally injecting bytes every 10 cycles.
    task automatic run_busy(input int which, input int nbytes, output int n, output int wip_low);
        logic en;
        n       = 0;
        wip_low = 0;
        for (int i = 0; i < 3000; i++) begin
            en = (which == 0) ? pp_enable : (which == 1) ? se_enable : be_enable;
            if (!en) break;
            n++;
            if (!wip) wip_low++;
            if (i > 0 && i % 10 == 0 && i / 10 <= nbytes) begin
                sel_n      = 1'b0;
                byte_valid = 1'b1;
                byte_in    = 8'h5A;
            end else begin
                sel_n      = 1'b1;
                byte_valid = 1'b0;
            end
            tick();
        end
        sel_n      = 1'b1;
        byte_valid = 1'b0;
    endtask

    initial begin
        int n, wl;
        rst_n      = 1'b0;
        sel_n      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) tick();
        chk_eq("rst_add_mem", 32'(add_mem), 32'h0);
        chk_eq("rst_wip",     32'(wip), 32'h0);
        chk_eq("rst_wel",     32'(wel), 32'h0);
        chk_eq("rst_cmd_err", 32'(cmd_err), 32'h0);
        rst_n = 1'b1;
        tick();

        // READ without WREN
        clr_acc();
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h23);
        chk_eq("rd_add_mem", 32'(add_mem), 32'h00123);
        chk_eq("rd_en_lag",  32'(read_enable), 32'h0);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hFF);
            if (i == 0) chk_eq("rd_en_high", 32'(read_enable), 32'h1);
            sel_n = 1'b0;
            tick();
        end
        chk_eq("rd_req_count", 32'(req_pulses), 32'd3);
        deselect();
        chk_eq("rd_en_fall", 32'(read_enable), 32'h0);

        // Page program with index wrap across FFh
        do_wren();
        chk_eq("wren_wel", 32'(wel), 32'h1);
        clr_acc();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hFE);
        chk_eq("pp_add_mem",  32'(add_mem), 32'h002FE);
        chk_eq("pp_idx_init", 32'(page_add_index), 32'hFD);
        send_byte(8'hAA);
        chk_eq("pp_idx0",    32'(page_add_index), 32'hFE);
        chk_eq("pp_dat0",    32'(data_to_write), 32'hAA);
        chk_eq("pp_add_en",  32'(add_pp_enable), 32'h1);
        send_byte(8'hBB);
        chk_eq("pp_idx1",    32'(page_add_index), 32'hFF);
        chk_eq("pp_dat1",    32'(data_to_write), 32'hBB);
        send_byte(8'hCC);
        chk_eq("pp_idx2",    32'(page_add_index), 32'h00);
        chk_eq("pp_dat2",    32'(data_to_write), 32'hCC);
        chk_eq("pp_en_data", 32'(acc_pp), 32'h0);
        deselect();
        chk_eq("pp_wip_set", 32'(wip), 32'h1);
        run_busy(0, 0, n, wl);
        chk_eq("pp_busy_len", 32'(n), 32'd64);
        chk_eq("pp_wip_gap",  32'(wl), 32'd0);
        chk_eq("pp_wip_end",  32'(wip), 32'h0);
        chk_eq("pp_wel_end",  32'(wel), 32'h0);
        chk_eq("pp_add_end",  32'(add_pp_enable), 32'h0);

        // PP without WREN
        clr_acc();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h11);
        deselect();
        chk_eq("wp_err",     32'(cmd_err), 32'h1);
        tick();
        chk_eq("wp_err_one", 32'(err_pulses), 32'd1);
        chk_eq("wp_no_add",  32'(acc_ppa), 32'h0);
        chk_eq("wp_no_pp",   32'(acc_pp), 32'h0);
        chk_eq("wp_wip",     32'(wip), 32'h0);

        // PP with no data bytes ends quietly
        do_wren();
        clr_acc();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        deselect();
        tick();
        chk_eq("pp0_no_err", 32'(err_pulses), 32'd0);
        chk_eq("pp0_no_add", 32'(acc_ppa | acc_pp), 32'h0);
        chk_eq("pp0_wel",    32'(wel), 32'h1);

        // WRDI, illegal opcode, early deselect
        send_byte(8'h04);
        deselect();
        chk_eq("wrdi_wel", 32'(wel), 32'h0);
        clr_acc();
        send_byte(8'h55);
        chk_eq("ill_err", 32'(cmd_err), 32'h1);
        deselect();
        chk_eq("ill_err_one", 32'(cmd_err), 32'h0);
        send_byte(8'h03);
        send_byte(8'h00);
        deselect();
        chk_eq("addr_desel_err", 32'(cmd_err), 32'h1);

        // Sector erase
        do_wren();
        send_byte(8'hD8);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        chk_eq("se_add_mem", 32'(add_mem), 32'h10000);
        deselect();
        chk_eq("se_en_rise", 32'(se_enable), 32'h1);
        run_busy(1, 0, n, wl);
        chk_eq("se_busy_len", 32'(n), 32'd256);
        chk_eq("se_wip_gap",  32'(wl), 32'd0);
        chk_eq("se_wel_end",  32'(wel), 32'h0);

        // SE with five bytes is rejected
        do_wren();
        clr_acc();
        send_byte(8'hD8);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        deselect();
        chk_eq("se5_err", 32'(cmd_err), 32'h1);
        tick();
        chk_eq("se5_no_se", 32'(acc_se), 32'h0);

        // Bulk erase with bytes arriving while busy
        do_wren();
        send_byte(8'hC7);
        deselect();
        chk_eq("be_en_rise", 32'(be_enable), 32'h1);
        clr_acc();
        run_busy(2, 3, n, wl);
        chk_eq("be_busy_len", 32'(n), 32'd1024);
        chk_eq("be_busy_err", 32'(err_pulses), 32'd3);
        chk_eq("be_wip_gap",  32'(wl), 32'd0);
        chk_eq("be_wel_end",  32'(wel), 32'h0);

        // Bulk erase aborted by reset
        do_wren();
        send_byte(8'hC7);
        deselect();
        repeat (100) tick();
        chk_eq("rbe_pre", 32'(be_enable), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_eq("rbe_be",      32'(be_enable), 32'h0);
        chk_eq("rbe_wip",     32'(wip), 32'h0);
        chk_eq("rbe_wel",     32'(wel), 32'h0);
        chk_eq("rbe_add_mem", 32'(add_mem), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        do_wren();
        chk_eq("rbe_resume_wel", 32'(wel), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
